// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: recognises SYNC/opcode/addr/data_hi/data_lo/checksum
// frames from a UART receiver and presents checked commands over a valid/ready handshake.
`timescale 1ns/1ps

module uart_cmd_parser #(
  parameter int          TIMEOUT_CYCLES = 2700,  // must be >= 2
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  DATA,
  input  logic        RXD_READY,
  input  logic        CMD_READY,
  output logic        CMD_VALID,
  output logic        CMD_WRITE,
  output logic [7:0]  CMD_ADDR,
  output logic [15:0] CMD_DATA,
  output logic        ERR_CHECKSUM,
  output logic        ERR_FRAME,
  output logic        ERR_TIMEOUT,
  output logic        ERR_OVERRUN,
  output logic        BUSY
);

  localparam logic [7:0] OPC_WRITE = 8'h57;
  localparam logic [7:0] OPC_READ  = 8'h52;
  localparam int         CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The timeout fires on the edge at which the idle count would reach TIMEOUT_CYCLES-1,
  // so the error pulse lands TIMEOUT_CYCLES-1 cycles after the last strobe.
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, OPC, ADDR, DHI, DLO, CSUM, OUT
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic            wr_q;
  logic [7:0]      addr_q, dhi_q, dlo_q, csum_q;
  logic            in_frame, timed_out, load_cmd;
  logic            err_checksum_d, err_frame_d, err_timeout_d, err_overrun_d;

  assign in_frame  = (state inside {OPC, ADDR, DHI, DLO, CSUM});
  assign timed_out = in_frame && !RXD_READY && (count == LAST_IDLE);
  assign CMD_VALID = (state == OUT);
  assign BUSY      = (state != IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state     = state;
    load_cmd       = 1'b0;
    err_checksum_d = 1'b0;
    err_frame_d    = 1'b0;
    err_timeout_d  = 1'b0;
    err_overrun_d  = 1'b0;
    case (state)
      IDLE: if (RXD_READY && DATA == SYNC_BYTE) next_state = OPC;
      OPC: if (RXD_READY) begin
        if (DATA == OPC_WRITE || DATA == OPC_READ) next_state = ADDR;
        else begin
          next_state  = IDLE;
          err_frame_d = 1'b1;
        end
      end
      ADDR: if (RXD_READY) next_state = DHI;
      DHI:  if (RXD_READY) next_state = DLO;
      DLO:  if (RXD_READY) next_state = CSUM;
      CSUM: if (RXD_READY) begin
        if (DATA == csum_q) begin
          next_state = OUT;
          load_cmd   = 1'b1;
        end else begin
          next_state     = IDLE;
          err_checksum_d = 1'b1;
        end
      end
      OUT: begin
        // Bytes during a pending command are dropped, including in the handshake cycle.
        err_overrun_d = RXD_READY;
        if (CMD_READY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (timed_out) begin
      next_state    = IDLE;
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      dhi_q        <= '0;
      dlo_q        <= '0;
      csum_q       <= '0;
      CMD_WRITE    <= 1'b0;
      CMD_ADDR     <= '0;
      CMD_DATA     <= '0;
      ERR_CHECKSUM <= 1'b0;
      ERR_FRAME    <= 1'b0;
      ERR_TIMEOUT  <= 1'b0;
      ERR_OVERRUN  <= 1'b0;
    end else begin
      ERR_CHECKSUM <= err_checksum_d;
      ERR_FRAME    <= err_frame_d;
      ERR_TIMEOUT  <= err_timeout_d;
      ERR_OVERRUN  <= err_overrun_d;

      if (in_frame && !RXD_READY && !timed_out) count <= count + 1'b1;
      else                                      count <= '0;

      if (RXD_READY) begin
        case (state)
          OPC: begin
            wr_q   <= (DATA == OPC_WRITE);
            csum_q <= DATA;
          end
          ADDR: begin
            addr_q <= DATA;
            csum_q <= csum_q ^ DATA;
          end
          DHI: begin
            dhi_q  <= DATA;
            csum_q <= csum_q ^ DATA;
          end
          DLO: begin
            dlo_q  <= DATA;
            csum_q <= csum_q ^ DATA;
          end
          default: ;
        endcase
      end

      if (load_cmd) begin
        CMD_WRITE <= wr_q;
        CMD_ADDR  <= addr_q;
        CMD_DATA  <= {dhi_q, dlo_q};
      end
    end
  end

endmodule
